// File: rtl/decode_issue_pkg.sv
// Shared types and constants for the banked decode/issue stage.
package decode_issue_pkg;

  typedef enum logic [0:0] {
    BANK_INT = 1'b0,
    BANK_FPU = 1'b1
  } bank_e;

  // Upper bounds for the write-back port struct; the stage zero-extends into them.
  localparam int XLEN_MAX = 64;
  localparam int AW_MAX   = 8;
  localparam int BW_MAX   = 4;

  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  typedef struct packed {
    logic                valid;
    logic [BW_MAX-1:0]   bank;
    logic [AW_MAX-1:0]   addr;
    logic [XLEN_MAX-1:0] data;
    logic                clr;
  } wb_port_t;

  function automatic int bw_of(input int nbank);
    return (nbank > 1) ? $clog2(nbank) : 1;
  endfunction

endpackage

// File: rtl/decode_issue_regbank.sv
// One register bank: flop array, NWB write ports, two bypassed read ports,
// optional hard-wired zero register at address 0.
module decode_issue_regbank
  import decode_issue_pkg::*;
#(
  parameter int  XLEN     = 32,
  parameter int  NREG     = 32,
  parameter int  NWB      = 2,
  parameter int  BANK_ID  = 0,
  parameter bit  ZERO_REG = 1'b0,
  localparam int AW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  wb_port_t        wb_i [NWB],
  input  logic [AW-1:0]   ra1_i,
  input  logic [AW-1:0]   ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [NWB-1:0]  we;
  logic            unused_ok;

  always_comb begin
    // NOTE: every variable written here gets a value first, so no latch is inferred.
    we        = '0;
    unused_ok = 1'b0;
    for (int p = 0; p < NWB; p++) begin
      we[p] = wb_i[p].valid
           && (wb_i[p].bank == BW_MAX'(BANK_ID))
           && (wb_i[p].addr < AW_MAX'(NREG))
           && !(ZERO_REG && (wb_i[p].addr == '0));
      unused_ok = unused_ok ^ wb_i[p].clr ^ (^wb_i[p].data);
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] ra);
    logic [XLEN-1:0] val;
    val = mem_q[ra];
    for (int p = 0; p < NWB; p++) begin
      if (we[p] && (wb_i[p].addr == AW_MAX'(ra))) val = wb_i[p].data[XLEN-1:0];
    end
    if (ZERO_REG && (ra == '0)) val = '0;
    return val;
  endfunction

  always_comb begin
    rd1_o = read_port(ra1_i);
    rd2_o = read_port(ra2_i);
  end

  // NOTE: the array is reset because architectural state must read 0 after reset;
  // non-blocking assignments let the later (higher-index) port win on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
    end else begin
      for (int p = 0; p < NWB; p++) begin
        if (we[p]) mem_q[wb_i[p].addr[AW-1:0]] <= wb_i[p].data[XLEN-1:0];
      end
    end
  end

endmodule

// File: rtl/decode_issue.sv
// Banked, scoreboarded decode/issue stage: operand read with write-back bypass,
// long-latency RAW/WAW stall and a registered valid/ready bundle to execute.
module decode_issue
  import decode_issue_pkg::*;
#(
  parameter int  XLEN       = 32,
  parameter int  NREG       = 32,
  parameter int  NBANK      = 2,
  parameter int  NWB        = 2,
  parameter bit  ZERO_BANK0 = 1'b1,
  localparam int AW         = $clog2(NREG),
  localparam int BW         = bw_of(NBANK)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     f_valid,
  output logic                     f_ready,
  input  logic [31:0]              f_instr,
  input  logic [XLEN-1:0]          f_pc,
  input  logic [XLEN-1:0]          f_pc_plus4,
  input  logic [BW-1:0]            c_rs1_bank,
  input  logic [BW-1:0]            c_rs2_bank,
  input  logic [BW-1:0]            c_rd_bank,
  input  logic                     c_use_rs1,
  input  logic                     c_use_rs2,
  input  logic                     c_rd_we,
  input  logic                     c_long,
  input  logic [NWB-1:0]           wb_valid,
  input  logic [NWB-1:0][BW-1:0]   wb_bank,
  input  logic [NWB-1:0][AW-1:0]   wb_addr,
  input  logic [NWB-1:0][XLEN-1:0] wb_data,
  input  logic [NWB-1:0]           wb_clr,
  input  logic                     flush,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic [XLEN-1:0]          d_rd1,
  output logic [XLEN-1:0]          d_rd2,
  output logic [31:0]              d_instr,
  output logic [XLEN-1:0]          d_pc,
  output logic [XLEN-1:0]          d_pc_plus4,
  output logic [AW-1:0]            d_rs1,
  output logic [AW-1:0]            d_rs2,
  output logic [AW-1:0]            d_rd,
  output logic [BW-1:0]            d_rd_bank,
  output logic                     d_rd_we,
  output logic                     d_long
);

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [BW-1:0]   rd_bank;
    logic            rd_we;
    logic            long_op;
  } bundle_t;

  logic [AW-1:0] rs1, rs2, rd;
  assign rs1 = f_instr[RS1_LSB +: AW];
  assign rs2 = f_instr[RS2_LSB +: AW];
  assign rd  = f_instr[RD_LSB  +: AW];

  wb_port_t wb_p [NWB];
  always_comb begin
    for (int p = 0; p < NWB; p++) begin
      wb_p[p] = '{valid: wb_valid[p], bank: BW_MAX'(wb_bank[p]), addr: AW_MAX'(wb_addr[p]),
                  data: XLEN_MAX'(wb_data[p]), clr: wb_clr[p]};
    end
  end

  logic [XLEN-1:0] bank_rd1 [NBANK];
  logic [XLEN-1:0] bank_rd2 [NBANK];

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    decode_issue_regbank #(
      .XLEN(XLEN), .NREG(NREG), .NWB(NWB), .BANK_ID(b),
      .ZERO_REG(ZERO_BANK0 && (b == 0))
    ) u_bank (
      .clk(clk), .rst_n(rst), .wb_i(wb_p),
      .ra1_i(rs1), .ra2_i(rs2), .rd1_o(bank_rd1[b]), .rd2_o(bank_rd2[b])
    );
  end

  logic [NBANK-1:0][NREG-1:0] busy_q, busy_d, clr_mask, pend;
  bundle_t                    bundle_q, bundle_d;
  logic                       d_valid_q, d_valid_d;
  logic [XLEN-1:0]            op1, op2;
  logic                       hazard, issue, zero_rd;

  always_comb begin
    op1      = '0;
    op2      = '0;
    clr_mask = '0;
    hazard   = 1'b0;
    for (int b = 0; b < NBANK; b++) begin
      if (c_rs1_bank == BW'(b)) op1 = bank_rd1[b];
      if (c_rs2_bank == BW'(b)) op2 = bank_rd2[b];
      for (int p = 0; p < NWB; p++) begin
        if (wb_clr[p] && (wb_bank[p] == BW'(b))) clr_mask[b][wb_addr[p]] = 1'b1;
      end
    end
    // A release arriving this cycle already counts as not pending.
    pend = busy_q & ~clr_mask;
    for (int b = 0; b < NBANK; b++) begin
      if (c_use_rs1 && (c_rs1_bank == BW'(b)) && pend[b][rs1]) hazard = 1'b1;
      if (c_use_rs2 && (c_rs2_bank == BW'(b)) && pend[b][rs2]) hazard = 1'b1;
      if (c_rd_we   && (c_rd_bank  == BW'(b)) && pend[b][rd])  hazard = 1'b1;
    end
  end

  assign zero_rd = ZERO_BANK0 && (c_rd_bank == BW'(BANK_INT)) && (rd == '0);
  assign f_ready = !hazard && (!d_valid_q || d_ready) && !flush;
  assign issue   = f_valid && f_ready;

  always_comb begin
    busy_d = busy_q & ~clr_mask;
    if (flush && d_valid_q && bundle_q.long_op && bundle_q.rd_we) begin
      for (int b = 0; b < NBANK; b++) begin
        if (bundle_q.rd_bank == BW'(b)) busy_d[b][bundle_q.rd] = 1'b0;
      end
    end
    // Applied last so a set beats a same-cycle clear of the same bit.
    if (issue && c_long && c_rd_we && !zero_rd) begin
      for (int b = 0; b < NBANK; b++) begin
        if (c_rd_bank == BW'(b)) busy_d[b][rd] = 1'b1;
      end
    end
  end

  always_comb begin
    bundle_d  = bundle_q;
    d_valid_d = d_valid_q;
    if (issue) begin
      bundle_d  = '{rd1: op1, rd2: op2, instr: f_instr, pc: f_pc, pc4: f_pc_plus4,
                    rs1: rs1, rs2: rs2, rd: rd, rd_bank: c_rd_bank,
                    rd_we: c_rd_we, long_op: c_long};
      d_valid_d = 1'b1;
    end else if (flush || d_ready) begin
      d_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_valid_q <= 1'b0;
      bundle_q  <= '0;
      busy_q    <= '0;
    end else begin
      d_valid_q <= d_valid_d;
      bundle_q  <= bundle_d;
      busy_q    <= busy_d;
    end
  end

  assign d_valid    = d_valid_q;
  assign d_rd1      = bundle_q.rd1;
  assign d_rd2      = bundle_q.rd2;
  assign d_instr    = bundle_q.instr;
  assign d_pc       = bundle_q.pc;
  assign d_pc_plus4 = bundle_q.pc4;
  assign d_rs1      = bundle_q.rs1;
  assign d_rs2      = bundle_q.rs2;
  assign d_rd       = bundle_q.rd;
  assign d_rd_bank  = bundle_q.rd_bank;
  assign d_rd_we    = bundle_q.rd_we;
  assign d_long     = bundle_q.long_op;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: flow, bypass, long-latency stall, backpressure,
// flush, zero register and asynchronous reset.
module tb_decode_issue;

  logic            clk = 1'b0;
  logic            rst;
  logic            f_valid, f_ready;
  logic [31:0]     f_instr, f_pc, f_pc_plus4;
  logic [0:0]      c_rs1_bank, c_rs2_bank, c_rd_bank;
  logic            c_use_rs1, c_use_rs2, c_rd_we, c_long;
  logic [1:0]      wb_valid, wb_clr;
  logic [1:0][0:0] wb_bank;
  logic [1:0][4:0] wb_addr;
  logic [1:0][31:0] wb_data;
  logic            flush, d_valid, d_ready;
  logic [31:0]     d_rd1, d_rd2, d_instr, d_pc, d_pc_plus4;
  logic [4:0]      d_rs1, d_rs2, d_rd;
  logic [0:0]      d_rd_bank;
  logic            d_rd_we, d_long;

  int total = 0;
  int bad   = 0;

  decode_issue dut (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_ready(f_ready), .f_instr(f_instr),
    .f_pc(f_pc), .f_pc_plus4(f_pc_plus4), .c_rs1_bank(c_rs1_bank), .c_rs2_bank(c_rs2_bank),
    .c_rd_bank(c_rd_bank), .c_use_rs1(c_use_rs1), .c_use_rs2(c_use_rs2), .c_rd_we(c_rd_we),
    .c_long(c_long), .wb_valid(wb_valid), .wb_bank(wb_bank), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_clr(wb_clr), .flush(flush), .d_valid(d_valid), .d_ready(d_ready),
    .d_rd1(d_rd1), .d_rd2(d_rd2), .d_instr(d_instr), .d_pc(d_pc), .d_pc_plus4(d_pc_plus4),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_rd_bank(d_rd_bank), .d_rd_we(d_rd_we),
    .d_long(d_long)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic b1, input logic b2, input logic bd,
                       input logic u1, input logic u2, input logic we, input logic lg);
    f_valid    = 1'b1;
    f_instr    = instr;
    f_pc       = pc;
    f_pc_plus4 = pc + 32'd4;
    c_rs1_bank = b1;
    c_rs2_bank = b2;
    c_rd_bank  = bd;
    c_use_rs1  = u1;
    c_use_rs2  = u2;
    c_rd_we    = we;
    c_long     = lg;
  endtask

  task automatic idle();
    f_valid   = 1'b0;
    c_use_rs1 = 1'b0;
    c_use_rs2 = 1'b0;
    c_rd_we   = 1'b0;
    c_long    = 1'b0;
  endtask

  task automatic set_wb(input int p, input logic bk, input logic [4:0] ad,
                        input logic [31:0] dt, input logic cl);
    wb_valid[p] = 1'b1;
    wb_bank[p]  = bk;
    wb_addr[p]  = ad;
    wb_data[p]  = dt;
    wb_clr[p]   = cl;
  endtask

  task automatic wb_none();
    wb_valid = '0;
    wb_clr   = '0;
  endtask

  logic [31:0] i_fadd, i_long7, i_waw7, i_rd_f0;

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    d_ready = 1'b1;
    f_instr = '0; f_pc = '0; f_pc_plus4 = '0;
    c_rs1_bank = '0; c_rs2_bank = '0; c_rd_bank = '0;
    wb_bank = '0; wb_addr = '0; wb_data = '0;
    idle();
    wb_none();
    #2;
    check("rst_d_valid", d_valid, 0);
    check("rst_d_rd1", d_rd1, 0);
    check("rst_d_instr", d_instr, 0);
    check("rst_f_ready", f_ready, 1);
    tick();
    rst = 1'b1;

    // Preload x3 from both ports; port 1 must win.
    set_wb(0, 1'b0, 5'd3, 32'h30, 1'b0);
    set_wb(1, 1'b0, 5'd3, 32'h33, 1'b0);
    tick();
    wb_none();

    // Back-to-back: addi x1, then add x2,x1,x3.
    drive(mk(5'd1, 5'd0, 5'd0), 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #3 check("b2b_f_ready_a", f_ready, 1);
    tick();
    check("b2b_valid_a", d_valid, 1);
    check("b2b_instr_a", d_instr, mk(5'd1, 5'd0, 5'd0));
    check("b2b_pc4_a", d_pc_plus4, 32'h104);
    drive(mk(5'd2, 5'd1, 5'd3), 32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    #3 check("b2b_f_ready_b", f_ready, 1);
    tick();
    check("b2b_valid_b", d_valid, 1);
    check("b2b_instr_b", d_instr, mk(5'd2, 5'd1, 5'd3));
    check("b2b_rd2_x3", d_rd2, 32'h33);
    check("b2b_rs1", d_rs1, 1);
    check("b2b_rd", d_rd, 2);

    // Same-cycle bypass into both banks.
    drive(mk(5'd0, 5'd5, 5'd5), 32'h108, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    set_wb(0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0);
    set_wb(1, 1'b1, 5'd5, 32'h1111, 1'b0);
    tick();
    wb_none();
    idle();
    check("byp_rd1", d_rd1, 32'hDEADBEEF);
    check("byp_rd2_fpu", d_rd2, 32'h1111);
    tick();
    check("drain_valid", d_valid, 0);

    // Long-latency RAW: fdiv f3, then fadd f4,f3,f2.
    drive(mk(5'd3, 5'd1, 5'd2), 32'h200, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    check("fdiv_valid", d_valid, 1);
    check("fdiv_long", d_long, 1);
    check("fdiv_rd_bank", d_rd_bank, 1);
    i_fadd = mk(5'd4, 5'd3, 5'd2);
    drive(i_fadd, 32'h204, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    #3 check("raw_stall_0", f_ready, 0);
    tick();
    check("raw_bubble", d_valid, 0);
    #3 check("raw_stall_1", f_ready, 0);
    tick();
    set_wb(0, 1'b1, 5'd3, 32'h4040, 1'b1);
    #3 check("raw_release", f_ready, 1);
    tick();
    wb_none();
    idle();
    check("raw_issue_valid", d_valid, 1);
    check("raw_issue_instr", d_instr, i_fadd);
    check("raw_issue_rd1", d_rd1, 32'h4040);
    tick();

    // Backpressure and flush of a long bundle writing f7.
    d_ready = 1'b0;
    i_long7 = mk(5'd7, 5'd3, 5'd0);
    drive(i_long7, 32'h300, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check("bp_valid", d_valid, 1);
    check("bp_rd1_f3", d_rd1, 32'h4040);
    i_waw7 = mk(5'd7, 5'd5, 5'd0);
    drive(i_waw7, 32'h304, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #3 check("bp_f_ready", f_ready, 0);
      tick();
      check("bp_hold_valid", d_valid, 1);
      check("bp_hold_instr", d_instr, i_long7);
      check("bp_hold_pc", d_pc, 32'h300);
    end
    flush = 1'b1;
    #3 check("flush_f_ready", f_ready, 0);
    tick();
    flush = 1'b0;
    check("flush_valid", d_valid, 0);
    #3 check("waw_released", f_ready, 1);
    tick();
    check("waw_issue_instr", d_instr, i_waw7);
    check("waw_issue_rd1_x5", d_rd1, 32'hDEADBEEF);

    // Flush blocks an issue attempt in the same cycle.
    d_ready = 1'b1;
    flush = 1'b1;
    drive(mk(5'd9, 5'd0, 5'd0), 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3 check("flush_blocks_issue", f_ready, 0);
    tick();
    flush = 1'b0;
    check("flush_blocks_valid", d_valid, 0);

    // Zero register: bank 0 x0 never becomes busy.
    drive(mk(5'd0, 5'd0, 5'd0), 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(mk(5'd8, 5'd0, 5'd0), 32'h504, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #3 check("zero_no_stall", f_ready, 1);
    tick();
    check("zero_valid", d_valid, 1);
    check("zero_rd1", d_rd1, 0);
    // Bank 1 f0 is an ordinary register and does stall.
    drive(mk(5'd0, 5'd0, 5'd0), 32'h508, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    i_rd_f0 = mk(5'd8, 5'd0, 5'd5);
    drive(i_rd_f0, 32'h50C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #3 check("f0_stall", f_ready, 0);
    tick();
    check("f0_stall_valid", d_valid, 0);

    // Asynchronous reset mid-stall, away from any rising edge.
    #3 rst = 1'b0;
    #1;
    check("arst_valid", d_valid, 0);
    check("arst_instr", d_instr, 0);
    check("arst_busy_clear", f_ready, 1);
    #1 rst = 1'b1;
    #1 check("post_rst_f_ready", f_ready, 1);
    tick();
    idle();
    check("post_rst_valid", d_valid, 1);
    check("post_rst_instr", d_instr, i_rd_f0);
    check("post_rst_rd2_x5", d_rd2, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
